fp_posit_acc_seq: RTL and testbench
===================================

Name: fp_posit_acc_seq

Overview:
Sequencer for the fp/posit fixed-point accumulator datapath. It takes a stream of aligned product terms, issues one term at a time to the accumulator, and feeds the running sum back as the accumulator input. It counts terms per vector, tracks sticky NaR and a watchdog, and emits one result per vector. It sits between the posit multiplier output stage and the result packer.

Parameters:
ACC_W, 32, accumulator fixed-point width
IN_W, 14, incoming term fixed-point width
EXP_W, 5, exponent width
LEN_W, 8, vector-length counter width
TIMEOUT, 15, max cycles waiting on acc_done before error

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
op_start  in  1  pulse: begin new vector; ignored unless IDLE
cfg_len  in  LEN_W  term count, sampled at op_start; 0 is legal
cfg_exp_set  in  EXP_W  alignment exponent, sampled at op_start
in_valid  in  1  term available
in_ready  out  1  term accepted when in_valid&&in_ready
in_sign  in  1  term sign
in_exp  in  EXP_W  term exponent
in_frac  in  IN_W  term magnitude
in_zero  in  1  term is zero
in_nar  in  1  term is NaR
acc_start  out  1  issue strobe to datapath
acc_sign, acc_zero, acc_nar  out  1 each  registered term flags
acc_exp_in  out  EXP_W  registered term exponent
acc_fixed_in  out  IN_W  registered term magnitude
acc_exp_set  out  EXP_W  latched cfg_exp_set
acc_fixed_acc  out  ACC_W  running sum fed to datapath
acc_done  in  1  datapath result valid
acc_fixed_out  in  ACC_W  datapath sum
res_valid  out  1  result valid, held until res_ready
res_ready  in  1  downstream accept
res_fixed  out  ACC_W  final sum
res_exp  out  EXP_W  equals latched exp_set
res_nar  out  1  sticky NaR over vector
res_err  out  1  watchdog fired during vector
busy  out  1  state != IDLE

Behaviour:
- Reset (sync, rst=1 at clk edge): state=IDLE. All outputs 0: in_ready, acc_*, res_*, busy. Term counter, sum, sticky flags and watchdog cleared. Reset mid-operation aborts with no result.
- IDLE: on op_start, latch cfg_len/cfg_exp_set and clear sum, nar and err. Go to FETCH, or to RESULT if cfg_len==0 (res_fixed=0).
- FETCH: in_ready=1. On handshake, register the term into acc_* regs. If in_zero, or sticky nar already set, skip issue: decrement count, no datapath use. Otherwise go to ISSUE.
- ISSUE: acc_start=1 for exactly one cycle, with acc_fixed_acc=current sum. Then go to WAIT.
- WAIT: acc_start=0; watchdog increments each cycle.
  - On acc_done=1: sum<=acc_fixed_out; nar|=acc_nar; decrement count; go to FETCH if count>0, else RESULT.
  - If watchdog reaches TIMEOUT: err=1 and go to RESULT, keeping the previous sum.
  - acc_done is sampled only in WAIT; it is ignored in any other state.
- Term issue latency: handshake at cycle t gives acc_start at t+1. The earliest next in_ready is the cycle after acc_done.
- RESULT: res_valid=1 with fixed outputs. On res_ready, go to IDLE the same edge. op_start in RESULT is ignored.
- in_nar: sets sticky nar at the handshake. Later terms are consumed (drained) but not issued. res_fixed=0 when res_nar=1.
- Arithmetic: the sequencer does no add. Sum width is ACC_W; datapath wrap-around passes through unchanged.
- Counter decrements saturate at 0, so count never wraps.

Decomposition:
- Shared package fp_posit_pkg: state enum (IDLE, FETCH, ISSUE, WAIT, RESULT), ACC_W/IN_W/EXP_W defaults, term struct {sign, exp, frac, zero, nar}.
- One natural sub-module: fp_posit_acc_wdog (watchdog counter with clear/enable/expire).

Test Plan:
- cfg_len=3, exp_set=4, terms (+,exp4,0x100), (+,exp5,0x100), (-,exp4,0x080); datapath model returns exact sums -> three acc_start pulses, res_fixed=0x280, res_exp=4, res_nar=0, res_err=0.
- cfg_len=0 with op_start -> res_valid on the 2nd cycle, res_fixed=0, no acc_start.
- cfg_len=4, second term in_zero=1 -> exactly 3 acc_start pulses, count reaches 0, result valid.
- cfg_len=3, first term in_nar=1 -> all 3 terms consumed, 0 acc_start pulses after it, res_nar=1, res_fixed=0.
- acc_done held low 15 cycles in WAIT -> res_err=1, res_valid=1, sum equals the pre-issue value; next vector clears err.
- rst asserted in WAIT with count=2, plus res_ready held low 10 cycles in RESULT -> after reset all outputs 0 and state IDLE; in the held case res_valid stays 1 with stable data.

Source files
------------

// File: rtl/fp_posit_pkg.sv
// Shared types and default widths for the fp/posit accumulator sequencer.
package fp_posit_pkg;

    localparam int ACC_W_DEF = 32;
    localparam int IN_W_DEF  = 14;
    localparam int EXP_W_DEF = 5;
    localparam int LEN_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT,
        RESULT
    } state_t;

    typedef struct packed {
        logic                 sign;
        logic [EXP_W_DEF-1:0] exp;
        logic [IN_W_DEF-1:0]  frac;
        logic                 zero;
        logic                 nar;
    } term_t;

endpackage

// File: rtl/fp_posit_acc_wdog.sv
// Watchdog: counts enabled cycles since the last clear and flags the TIMEOUT-th one.
module fp_posit_acc_wdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_reg;

    assign expire = en && (cnt_reg == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_reg <= '0;
        end else if (en && !expire) begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

endmodule

// File: rtl/fp_posit_acc_seq.sv
// Term sequencer for the fixed-point accumulator: issues one term at a time,
// feeds back the running sum and emits one result per vector.
module fp_posit_acc_seq
    import fp_posit_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int IN_W    = IN_W_DEF,
    parameter int EXP_W   = EXP_W_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [EXP_W-1:0] cfg_exp_set,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [IN_W-1:0]  in_frac,
    input  logic             in_zero,
    input  logic             in_nar,
    output logic             acc_start,
    output logic             acc_sign,
    output logic             acc_zero,
    output logic             acc_nar,
    output logic [EXP_W-1:0] acc_exp_in,
    output logic [IN_W-1:0]  acc_fixed_in,
    output logic [EXP_W-1:0] acc_exp_set,
    output logic [ACC_W-1:0] acc_fixed_acc,
    input  logic             acc_done,
    input  logic [ACC_W-1:0] acc_fixed_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_fixed,
    output logic [EXP_W-1:0] res_exp,
    output logic             res_nar,
    output logic             res_err,
    output logic             busy
);

    state_t           state_reg;
    term_t            term_reg;
    logic [LEN_W-1:0] count_reg;
    logic [LEN_W-1:0] count_next;
    logic [EXP_W-1:0] exp_set_reg;
    logic [ACC_W-1:0] sum_reg;
    logic             nar_reg;
    logic             err_reg;
    logic             in_ready_reg;
    logic             acc_start_reg;
    logic             res_valid_reg;
    logic             busy_reg;
    logic             wd_clr;
    logic             wd_en;
    logic             wd_expire;

    // Saturating decrement so a stray decrement can never wrap the count.
    assign count_next = (count_reg == '0) ? '0 : count_reg - LEN_W'(1);

    assign wd_clr = (state_reg == ISSUE);
    assign wd_en  = (state_reg == WAIT);

    fp_posit_acc_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (wd_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            term_reg      <= '0;
            count_reg     <= '0;
            exp_set_reg   <= '0;
            sum_reg       <= '0;
            nar_reg       <= 1'b0;
            err_reg       <= 1'b0;
            in_ready_reg  <= 1'b0;
            acc_start_reg <= 1'b0;
            res_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            acc_start_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (op_start) begin
                        count_reg   <= cfg_len;
                        exp_set_reg <= cfg_exp_set;
                        sum_reg     <= '0;
                        nar_reg     <= 1'b0;
                        err_reg     <= 1'b0;
                        busy_reg    <= 1'b1;
                        if (cfg_len == '0) begin
                            state_reg     <= RESULT;
                            res_valid_reg <= 1'b1;
                        end else begin
                            state_reg    <= FETCH;
                            in_ready_reg <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (in_valid) begin
                        term_reg.sign <= in_sign;
                        term_reg.exp  <= in_exp;
                        term_reg.frac <= in_frac;
                        term_reg.zero <= in_zero;
                        term_reg.nar  <= in_nar;
                        if (in_nar) begin
                            nar_reg <= 1'b1;
                        end
                        // Zero terms and anything after a NaR are drained without a datapath trip.
                        if (in_zero || nar_reg) begin
                            count_reg <= count_next;
                            if (count_next == '0) begin
                                state_reg     <= RESULT;
                                in_ready_reg  <= 1'b0;
                                res_valid_reg <= 1'b1;
                            end
                        end else begin
                            state_reg     <= ISSUE;
                            in_ready_reg  <= 1'b0;
                            acc_start_reg <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (acc_done) begin
                        sum_reg   <= acc_fixed_out;
                        nar_reg   <= nar_reg | term_reg.nar;
                        count_reg <= count_next;
                        if (count_next != '0) begin
                            state_reg    <= FETCH;
                            in_ready_reg <= 1'b1;
                        end else begin
                            state_reg     <= RESULT;
                            res_valid_reg <= 1'b1;
                        end
                    end else if (wd_expire) begin
                        err_reg       <= 1'b1;
                        state_reg     <= RESULT;
                        res_valid_reg <= 1'b1;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        state_reg     <= IDLE;
                        res_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready      = in_ready_reg;
    assign acc_start     = acc_start_reg;
    assign acc_sign      = term_reg.sign;
    assign acc_zero      = term_reg.zero;
    assign acc_nar       = term_reg.nar;
    assign acc_exp_in    = term_reg.exp;
    assign acc_fixed_in  = term_reg.frac;
    assign acc_exp_set   = exp_set_reg;
    assign acc_fixed_acc = sum_reg;
    assign res_valid     = res_valid_reg;
    assign res_fixed     = nar_reg ? '0 : sum_reg;
    assign res_exp       = exp_set_reg;
    assign res_nar       = nar_reg;
    assign res_err       = err_reg;
    assign busy          = busy_reg;

endmodule

// File: tb/tb_fp_posit_acc_seq.sv
// Randomized bench for fp_posit_acc_seq against a vector-level reference model.
module tb_fp_posit_acc_seq;

    localparam int ACC_W   = 32;
    localparam int IN_W    = 14;
    localparam int EXP_W   = 5;
    localparam int LEN_W   = 8;
    localparam int TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             op_start = 1'b0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic [EXP_W-1:0] cfg_exp_set = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_sign = 1'b0;
    logic [EXP_W-1:0] in_exp = '0;
    logic [IN_W-1:0]  in_frac = '0;
    logic             in_zero = 1'b0;
    logic             in_nar = 1'b0;
    logic             acc_start;
    logic             acc_sign;
    logic             acc_zero;
    logic             acc_nar;
    logic [EXP_W-1:0] acc_exp_in;
    logic [IN_W-1:0]  acc_fixed_in;
    logic [EXP_W-1:0] acc_exp_set;
    logic [ACC_W-1:0] acc_fixed_acc;
    logic             acc_done = 1'b0;
    logic [ACC_W-1:0] acc_fixed_out = '0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [ACC_W-1:0] res_fixed;
    logic [EXP_W-1:0] res_exp;
    logic             res_nar;
    logic             res_err;
    logic             busy;

    fp_posit_acc_seq #(
        .ACC_W(ACC_W), .IN_W(IN_W), .EXP_W(EXP_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .op_start(op_start), .cfg_len(cfg_len),
        .cfg_exp_set(cfg_exp_set), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_frac(in_frac), .in_zero(in_zero),
        .in_nar(in_nar), .acc_start(acc_start), .acc_sign(acc_sign),
        .acc_zero(acc_zero), .acc_nar(acc_nar), .acc_exp_in(acc_exp_in),
        .acc_fixed_in(acc_fixed_in), .acc_exp_set(acc_exp_set),
        .acc_fixed_acc(acc_fixed_acc), .acc_done(acc_done),
        .acc_fixed_out(acc_fixed_out), .res_valid(res_valid), .res_ready(res_ready),
        .res_fixed(res_fixed), .res_exp(res_exp), .res_nar(res_nar),
        .res_err(res_err), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int   n_terms;
    bit   t_sign [16];
    int   t_exp  [16];
    int   t_frac [16];
    bit   t_zero [16];
    bit   t_nar  [16];
    int   stall_k = 1000;
    int   issue_idx = 0;
    int   pulses = 0;
    int   stall_wait = 0;
    logic [31:0] exp_acc_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        checks++;
        if (obs !== req) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, req);
        end
    endtask

    // Aligned signed value of a term relative to the vector's exponent.
    function automatic int term_val(input bit s, input int e, input int f, input int es);
        int mag;
        mag = (e >= es) ? (f << (e - es)) : (f >> (es - e));
        return s ? -mag : mag;
    endfunction

    // Datapath stand-in: answers each issue after a random latency unless stalled.
    initial begin
        logic [31:0] base;
        int v;
        int w;
        forever begin
            @(negedge clk);
            if (acc_start === 1'b1) begin
                pulses++;
                chk("issue_expected", 64'(exp_acc_q.size() > 0), 64'd1);
                if (exp_acc_q.size() > 0) chk("issue_acc_in", 64'(acc_fixed_acc), 64'(exp_acc_q.pop_front()));
                base = acc_fixed_acc;
                v = term_val(acc_sign, int'(acc_exp_in), int'(acc_fixed_in), int'(acc_exp_set));
                if (issue_idx >= stall_k) begin
                    issue_idx++;
                    w = 0;
                    while (res_valid !== 1'b1 && w < 40) begin
                        @(negedge clk);
                        w++;
                    end
                    stall_wait = w;
                end else begin
                    issue_idx++;
                    repeat ($urandom_range(1, 4)) @(negedge clk);
                    acc_done = 1'b1;
                    acc_fixed_out = base + 32'(v);
                    @(negedge clk);
                    acc_done = 1'b0;
                    acc_fixed_out = $urandom;
                end
            end
        end
    end

    task automatic set_term(input int i, input bit s, input int e, input int f, input bit z, input bit n);
        t_sign[i] = s; t_exp[i] = e; t_frac[i] = f; t_zero[i] = z; t_nar[i] = n;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_acc_start"}, 64'(acc_start), 64'd0);
        chk({tag, "_acc_flags"}, 64'({acc_sign, acc_zero, acc_nar}), 64'd0);
        chk({tag, "_acc_terms"}, 64'({acc_exp_in, acc_fixed_in, acc_exp_set}), 64'd0);
        chk({tag, "_acc_sum"}, 64'(acc_fixed_acc), 64'd0);
        chk({tag, "_res_valid"}, 64'(res_valid), 64'd0);
        chk({tag, "_res_data"}, 64'({res_fixed, res_exp, res_nar, res_err}), 64'd0);
    endtask

    task automatic run_vec(input int len, input int es, input int hold);
        logic [31:0] sum;
        bit          nar;
        bit          err;
        int          issued;
        bit          iss [16];
        int          bound;
        logic [31:0] want_fixed;

        sum = '0; nar = 0; err = 0; issued = 0;
        exp_acc_q.delete();
        for (int i = 0; i < len; i++) begin
            iss[i] = 0;
            if (err) continue;
            if (!(t_zero[i] || nar)) begin
                exp_acc_q.push_back(sum);
                iss[i] = 1;
                if (issued == stall_k) err = 1;
                else sum = sum + 32'(term_val(t_sign[i], t_exp[i], t_frac[i], es));
                issued++;
            end
            if (t_nar[i]) nar = 1;
        end
        want_fixed = nar ? 32'd0 : sum;
        n_terms = len;
        pulses = 0;
        issue_idx = 0;
        stall_wait = -1;

        @(negedge clk);
        op_start = 1'b1; cfg_len = LEN_W'(len); cfg_exp_set = EXP_W'(es);
        @(negedge clk);
        op_start = 1'b0;
        if (len == 0) chk("len0_latency", 64'(res_valid), 64'd1);

        for (int i = 0; i < len; i++) begin
            if (res_valid === 1'b1) break;
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1; in_sign = t_sign[i]; in_exp = EXP_W'(t_exp[i]);
            in_frac = IN_W'(t_frac[i]); in_zero = t_zero[i]; in_nar = t_nar[i];
            bound = 0;
            while (in_ready !== 1'b1 && res_valid !== 1'b1 && bound < 300) begin
                @(negedge clk);
                bound++;
            end
            if (in_ready === 1'b1) begin
                @(negedge clk);
                in_valid = 1'b0;
                chk("issue_latency", 64'(acc_start), 64'(iss[i]));
            end else begin
                chk("in_ready_wait", 64'(bound < 300), 64'd1);
                break;
            end
        end
        in_valid = 1'b0;

        bound = 0;
        while (res_valid !== 1'b1 && bound < 300) begin
            @(negedge clk);
            bound++;
        end
        chk("res_valid", 64'(res_valid), 64'd1);
        if (err) chk("wdog_cycles", 64'(stall_wait), 64'(TIMEOUT + 1));
        chk("res_fixed", 64'(res_fixed), 64'(want_fixed));
        chk("res_exp", 64'(res_exp), 64'(es));
        chk("res_nar", 64'(res_nar), 64'(nar));
        chk("res_err", 64'(res_err), 64'(err));
        chk("acc_pulses", 64'(pulses), 64'(issued));
        chk("busy_result", 64'(busy), 64'd1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 64'(res_valid), 64'd1);
            chk("hold_fixed", 64'(res_fixed), 64'(want_fixed));
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("res_release", 64'(res_valid), 64'd0);
        chk("busy_idle", 64'(busy), 64'd0);
        $display("vec len=%0d exp_set=%0d issued=%0d fixed=%0h nar=%0d err=%0d", len, es, issued, want_fixed, nar, err);
    endtask

    initial begin
        int len;
        int es;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        // Worked example: exp 5 term aligns to 0x200, total 0x280.
        set_term(0, 0, 4, 'h100, 0, 0);
        set_term(1, 0, 5, 'h100, 0, 0);
        set_term(2, 1, 4, 'h080, 0, 0);
        run_vec(3, 4, 0);

        run_vec(0, 3, 0);

        set_term(0, 0, 2, 'h011, 0, 0);
        set_term(1, 0, 2, 'h022, 1, 0);
        set_term(2, 1, 3, 'h033, 0, 0);
        set_term(3, 0, 1, 'h044, 0, 0);
        run_vec(4, 2, 1);

        set_term(0, 0, 1, 'h055, 0, 1);
        set_term(1, 0, 1, 'h066, 0, 0);
        set_term(2, 1, 1, 'h077, 0, 0);
        run_vec(3, 1, 0);

        stall_k = 1;
        set_term(0, 0, 0, 'h040, 0, 0);
        set_term(1, 0, 0, 'h041, 0, 0);
        set_term(2, 0, 0, 'h042, 0, 0);
        run_vec(3, 0, 0);
        stall_k = 1000;
        run_vec(3, 0, 0);

        // Reset while waiting on the datapath with two terms still owed.
        stall_k = 0;
        issue_idx = 0;
        exp_acc_q.delete();
        exp_acc_q.push_back(32'd0);
        @(negedge clk);
        op_start = 1'b1; cfg_len = 3; cfg_exp_set = 2;
        @(negedge clk);
        op_start = 1'b0;
        in_valid = 1'b1; in_sign = 1'b1; in_exp = 3; in_frac = 'h123; in_zero = 0; in_nar = 0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst_pre_issue", 64'(acc_start), 64'd1);
        repeat (3) @(negedge clk);
        chk("rst_pre_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("midop_reset");
        rst = 1'b0;
        repeat (45) @(negedge clk);
        stall_k = 1000;

        set_term(0, 0, 6, 'h3ff, 0, 0);
        set_term(1, 1, 2, 'h100, 0, 0);
        run_vec(2, 3, 10);

        for (int v = 0; v < 30; v++) begin
            len = $urandom_range(0, 6);
            es = $urandom_range(0, 7);
            for (int i = 0; i < len; i++)
                set_term(i, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 16383),
                         $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
            stall_k = ($urandom_range(0, 9) == 0 && len > 0) ? $urandom_range(0, len - 1) : 1000;
            run_vec(len, es, $urandom_range(0, 3));
            if (stall_k != 1000) repeat (45) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
